// File: rtl/vx_operands_arb.sv
// Purpose: round-robin arbiter that merges NUM_REQS operand collectors onto one dispatch port through a 2-entry in-order buffer.
// Latency: a bundle accepted in cycle N is presented on rsp_* in cycle N+1 when the buffer is empty; sustains 1 bundle/cycle.
// Backpressure: req_ready depends only on buffer occupancy (count<2), never on rsp_ready, so the dispatch side cannot form a loop into requesters.
module vx_operands_arb #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 512,
  parameter int SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      rsp_valid,
  output logic [DATAW-1:0]          rsp_data,
  output logic [SELW-1:0]           rsp_sel,
  input  logic                      rsp_ready
);

  // Buffer state: head entry drives rsp_* directly; tail holds the second bundle when count==2.
  logic [1:0]       count;
  logic [SELW-1:0]  rr_ptr;
  logic [DATAW-1:0] head_data;
  logic [SELW-1:0]  head_sel;
  logic [DATAW-1:0] tail_data;
  logic [SELW-1:0]  tail_sel;

  logic             found;
  logic [SELW-1:0]  win;
  logic [SELW-1:0]  rr_next;
  logic [DATAW-1:0] win_data;
  logic             push;
  logic             pop;

  // Round-robin scan: first valid requester starting at rr_ptr, wrapping modulo NUM_REQS.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQS;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = SELW'(idx);
      end
    end
  end

  assign win_data  = req_data[int'(win)*DATAW +: DATAW];
  assign rr_next   = (int'(win) == NUM_REQS - 1) ? '0 : win + SELW'(1);
  assign push      = found && (count < 2'd2) && reset;
  assign rsp_valid = (count != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = head_data;
  assign rsp_sel   = head_sel;

  // One-hot grant to the winner, only when a slot is free; held low during reset.
  always_comb begin
    req_ready = '0;
    if (push) begin
      req_ready[win] = 1'b1;
    end
  end

  // Buffer update: pop shifts tail to head; push writes into the first free slot after the pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= 2'd0;
      rr_ptr    <= '0;
      head_data <= '0;
      head_sel  <= '0;
      tail_data <= '0;
      tail_sel  <= '0;
    end else begin
      if (pop && count == 2'd2) begin
        head_data <= tail_data;
        head_sel  <= tail_sel;
      end
      if (push) begin
        if (count == 2'd0 || (count == 2'd1 && pop)) begin
          head_data <= win_data;
          head_sel  <= win;
        end else begin
          tail_data <= win_data;
          tail_sel  <= win;
        end
        rr_ptr <= rr_next;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_operands_arb.sv
// Purpose: self-checking bench for vx_operands_arb against a queue-based reference model.
// Latency: model pushes/pops at each rising edge; DUT outputs are compared 2 time units after the edge.
// Backpressure: rsp_ready is driven by the scenarios; requesters hold data until the model sees an accept.
module tb_vx_operands_arb;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  vld;
  logic [N*DW-1:0] rdat;
  logic [N-1:0]  rrdy;
  logic          rspv;
  logic [DW-1:0] rspd;
  logic [SW-1:0] rsps;
  logic          rspr;

  logic [DW-1:0] bund [N];

  // Reference model: FIFO of accepted bundles and the round-robin pointer.
  logic [DW-1:0] qd [$];
  int            qs [$];
  int            rr;
  int            n_tests;
  int            n_fail;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign rdat[g*DW +: DW] = bund[g];
  end

  vx_operands_arb #(.NUM_REQS(N), .DATAW(DW)) dut (
    .clk(clk), .reset(rst), .req_valid(vld), .req_data(rdat), .req_ready(rrdy),
    .rsp_valid(rspv), .rsp_data(rspd), .rsp_sel(rsps), .rsp_ready(rspr)
  );

  function automatic logic [DW-1:0] rnd_bundle();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int winner();
    for (int k = 0; k < N; k++) begin
      if (vld[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = winner();
    if (rst && w >= 0 && qd.size() < 2) r[w] = 1'b1;
    return r;
  endfunction

  // Advance one clock and apply the model's push/pop; refresh a requester's data once accepted.
  task automatic tick();
    int w;
    bit push, pop;
    w    = winner();
    push = rst && (w >= 0) && (qd.size() < 2);
    pop  = rst && (qd.size() > 0) && rspr;
    @(posedge clk);
    #1;
    if (!rst) begin
      qd.delete();
      qs.delete();
      rr = 0;
    end else begin
      if (pop) begin
        void'(qd.pop_front());
        void'(qs.pop_front());
      end
      if (push) begin
        qd.push_back(bund[w]);
        qs.push_back(w);
        rr = (w + 1) % N;
        bund[w] = rnd_bundle();
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    vld = '0;
    rspr = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; vld = '1; rspr = 1'b1;
    #1;
    n_tests++;
    if (rrdy !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", rrdy); end
    tick(); tick();
    n_tests++;
    if (rspv !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rspv); end
    n_tests++;
    if (rspd !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rspd); end
    n_tests++;
    if (rsps !== '0) begin n_fail++; $display("FAIL reset_rsp_sel: got %0d want 0", rsps); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    vld = 4'b0001; rspr = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_tests++;
      if (rrdy !== exp_ready() || rrdy !== 4'b0001) begin
        n_fail++; $display("FAIL single_ready c%0d: got %b want 0001", c, rrdy);
      end
      n_tests++;
      if (rspv !== (c > 0)) begin n_fail++; $display("FAIL single_rsp_valid c%0d: got %b want %b", c, rspv, c > 0); end
      if (qd.size() > 0) begin
        n_tests++;
        if (rspd !== qd[0] || rsps !== SW'(qs[0])) begin
          n_fail++; $display("FAIL single_rsp c%0d: got sel %0d data %h want sel %0d data %h", c, rsps, rspd, qs[0], qd[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_rr_all();
    logic [N-1:0] e;
    do_reset();
    vld = '1; rspr = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      e = N'(1) << (c % N);
      n_tests++;
      if (rrdy !== e) begin n_fail++; $display("FAIL rr_all_grant c%0d: got %b want %b", c, rrdy, e); end
      if (c > 0) begin
        n_tests++;
        if (rspv !== 1'b1 || rsps !== SW'((c - 1) % N) || rspd !== qd[0]) begin
          n_fail++; $display("FAIL rr_all_rsp c%0d: got v%b sel %0d want v1 sel %0d", c, rspv, rsps, (c - 1) % N);
        end
      end
      tick();
    end
  endtask

  task automatic test_rr_skip();
    int gseq [3];
    int hseq [3];
    gseq = '{3, 1, 3};
    hseq = '{1, 3, 1};
    do_reset();
    vld = 4'b0010; rspr = 1'b1;
    tick();
    vld = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (rrdy !== (N'(1) << gseq[c])) begin
        n_fail++; $display("FAIL rr_skip_grant c%0d: got %b want req %0d", c, rrdy, gseq[c]);
      end
      n_tests++;
      if (rspv !== 1'b1 || rsps !== SW'(hseq[c])) begin
        n_fail++; $display("FAIL rr_skip_head c%0d: got v%b sel %0d want v1 sel %0d", c, rspv, rsps, hseq[c]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] first, second;
    do_reset();
    vld = 4'b0100; rspr = 1'b0;
    first = bund[2];
    #1;
    n_tests++;
    if (rrdy !== 4'b0100) begin n_fail++; $display("FAIL bp_accept0: got %b want 0100", rrdy); end
    tick();
    second = bund[2];
    #1;
    n_tests++;
    if (rrdy !== 4'b0100) begin n_fail++; $display("FAIL bp_accept1: got %b want 0100", rrdy); end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (rrdy !== 4'b0000) begin n_fail++; $display("FAIL bp_full c%0d: got %b want 0000", c, rrdy); end
      n_tests++;
      if (rspv !== 1'b1 || rspd !== first || rsps !== 2'd2) begin
        n_fail++; $display("FAIL bp_hold c%0d: got v%b sel %0d data %h want v1 sel 2 data %h", c, rspv, rsps, rspd, first);
      end
      tick();
    end
    rspr = 1'b1;
    #1;
    n_tests++;
    if (rrdy !== 4'b0000) begin n_fail++; $display("FAIL bp_pop_ready: got %b want 0000", rrdy); end
    tick();
    rspr = 1'b0;
    #1;
    n_tests++;
    if (rrdy !== 4'b0100) begin n_fail++; $display("FAIL bp_after_pop_ready: got %b want 0100", rrdy); end
    n_tests++;
    if (rspv !== 1'b1 || rspd !== second || rsps !== 2'd2) begin
      n_fail++; $display("FAIL bp_second_head: got v%b sel %0d data %h want v1 sel 2 data %h", rspv, rsps, rspd, second);
    end
    vld = '0; rspr = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] a, b;
    do_reset();
    rspr = 1'b0; vld = 4'b0001; a = bund[0];
    tick();
    vld = 4'b0010; b = bund[1]; rspr = 1'b1;
    #1;
    n_tests++;
    if (rspv !== 1'b1 || rspd !== a || rrdy !== 4'b0010) begin
      n_fail++; $display("FAIL pp_before: got v%b rdy %b data %h want v1 rdy 0010 data %h", rspv, rrdy, rspd, a);
    end
    tick();
    vld = '0;
    #1;
    n_tests++;
    if (rspv !== 1'b1 || rspd !== b || rsps !== 2'd1) begin
      n_fail++; $display("FAIL pp_after: got v%b sel %0d data %h want v1 sel 1 data %h", rspv, rsps, rspd, b);
    end
    tick();
    #1;
    n_tests++;
    if (rspv !== 1'b0) begin n_fail++; $display("FAIL pp_drained: got v%b want v0", rspv); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rspr = 1'b0; vld = 4'b0011;
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; vld = 4'b1100;
    #1;
    n_tests++;
    if (rspv !== 1'b0 || rsps !== '0) begin
      n_fail++; $display("FAIL midrst_rsp: got v%b sel %0d want v0 sel 0", rspv, rsps);
    end
    n_tests++;
    if (rrdy !== 4'b0100) begin n_fail++; $display("FAIL midrst_grant: got %b want 0100", rrdy); end
    tick();
    n_tests++;
    if (rspv !== 1'b1 || rsps !== 2'd2) begin
      n_fail++; $display("FAIL midrst_first: got v%b sel %0d want v1 sel 2", rspv, rsps);
    end
    vld = '0; rspr = 1'b1;
    tick(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 99) != 0);
      vld  = N'($urandom);
      rspr = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++;
      if (rrdy !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, rrdy, exp_ready()); end
      n_tests++;
      if (rspv !== (qd.size() > 0)) begin n_fail++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, rspv, qd.size() > 0); end
      if (qd.size() > 0) begin
        n_tests++;
        if (rspd !== qd[0] || rsps !== SW'(qs[0])) begin
          n_fail++; $display("FAIL rnd_rsp c%0d: got sel %0d data %h want sel %0d data %h", c, rsps, rspd, qs[0], qd[0]);
        end
      end
      tick();
    end
    rst = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rr      = 0;
    rst     = 1'b0;
    vld     = '0;
    rspr    = 1'b0;
    for (int i = 0; i < N; i++) bund[i] = rnd_bundle();
    test_reset();
    test_single();
    test_rr_all();
    test_rr_skip();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
